// File: rtl/eth_rx_noc_out_arb_if.sv
// Flit channel bundle between the per-stream noc_out blocks, the arbiter
// and the noc0 vrtoc port. The arbiter sits on the slave side.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

interface eth_rx_noc_out_arb_if #(
   parameter int NUM_SRCS = 2,
   parameter int DATA_W   = `NOC_DATA_WIDTH
);
   logic [NUM_SRCS-1:0]        src_noc0_vrtoc_val;
   logic [NUM_SRCS*DATA_W-1:0] src_noc0_vrtoc_data;
   logic [NUM_SRCS-1:0]        noc0_vrtoc_src_rdy;
   logic                       eth_rx_out_noc0_vrtoc_val;
   logic [DATA_W-1:0]          eth_rx_out_noc0_vrtoc_data;
   logic                       noc0_vrtoc_eth_rx_out_rdy;

   modport master (
      output src_noc0_vrtoc_val,
      output src_noc0_vrtoc_data,
      output noc0_vrtoc_eth_rx_out_rdy,
      input  noc0_vrtoc_src_rdy,
      input  eth_rx_out_noc0_vrtoc_val,
      input  eth_rx_out_noc0_vrtoc_data
   );

   modport slave (
      input  src_noc0_vrtoc_val,
      input  src_noc0_vrtoc_data,
      input  noc0_vrtoc_eth_rx_out_rdy,
      output noc0_vrtoc_src_rdy,
      output eth_rx_out_noc0_vrtoc_val,
      output eth_rx_out_noc0_vrtoc_data
   );
endinterface

// File: rtl/eth_rx_noc_out_arb.sv
// Packet-level round-robin arbiter merging NUM_SRCS flit streams onto the
// single eth_rx noc0 output. A grant is held from header to last body flit;
// the body length comes from the msg_len field of the header flit.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  ARB   | no packet open; winner picked combinationally from prio_ptr
//  BODY  | packet open on grant; flits_left body flits still to send
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

module eth_rx_noc_out_arb #(
   parameter int NUM_SRCS    = 2,
   parameter int DATA_W      = `NOC_DATA_WIDTH,
   parameter int MSG_LEN_LSB = 0,
   parameter int MSG_LEN_W   = 8,
   localparam int GIDX_W     = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   eth_rx_noc_out_arb_if.slave  bus,
   output logic [GIDX_W-1:0]    arb_grant_idx,
   output logic                 arb_pkt_done
);

   typedef enum logic {ARB, BODY} state_t;

   state_t                state_q, state_d;
   logic [GIDX_W-1:0]     prio_q, prio_d;
   logic [GIDX_W-1:0]     grant_q, grant_d;
   logic [MSG_LEN_W-1:0]  flits_left_q, flits_left_d;
   logic                  pkt_done_d;

   logic [GIDX_W-1:0]     cand;
   logic [GIDX_W-1:0]     arb_win;
   logic                  arb_found;
   logic [GIDX_W-1:0]     sel;
   logic                  sel_val;
   logic [DATA_W-1:0]     sel_data;
   logic [MSG_LEN_W-1:0]  hdr_len;
   logic                  out_val;
   logic                  xfer;

   function automatic logic [GIDX_W-1:0] wrap_inc(input logic [GIDX_W-1:0] x);
      if (x == GIDX_W'(NUM_SRCS - 1))
         return '0;
      else
         return x + GIDX_W'(1);
   endfunction

   // Round-robin scan: first valid source starting at prio_q.
   always_comb begin
      arb_found = 1'b0;
      arb_win   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_SRCS; k++) begin
         cand = GIDX_W'((int'(prio_q) + k) % NUM_SRCS);
         if (!arb_found && bus.src_noc0_vrtoc_val[cand]) begin
            arb_found = 1'b1;
            arb_win   = cand;
         end
      end
   end

   assign sel      = (state_q == BODY) ? grant_q : arb_win;
   assign sel_val  = bus.src_noc0_vrtoc_val[sel];
   assign sel_data = bus.src_noc0_vrtoc_data[int'(sel)*DATA_W +: DATA_W];
   assign hdr_len  = sel_data[MSG_LEN_LSB +: MSG_LEN_W];

   // With no requester in ARB every val is low, so sel_val is low as well.
   assign out_val = ~rst & sel_val;
   assign xfer    = out_val & bus.noc0_vrtoc_eth_rx_out_rdy;

   assign bus.eth_rx_out_noc0_vrtoc_val  = out_val;
   assign bus.eth_rx_out_noc0_vrtoc_data = sel_data;
   assign arb_grant_idx                  = (state_q == BODY) ? grant_q : arb_win;

   // Ready steering: only the selected source sees the NoC ready.
   always_comb begin
      bus.noc0_vrtoc_src_rdy = '0;
      if (!rst && ((state_q == BODY) || arb_found))
         bus.noc0_vrtoc_src_rdy[sel] = bus.noc0_vrtoc_eth_rx_out_rdy;
   end

   // Next-state: open a packet on a header, count body flits, close on the last one.
   always_comb begin
      state_d      = state_q;
      prio_d       = prio_q;
      grant_d      = grant_q;
      flits_left_d = flits_left_q;
      pkt_done_d   = 1'b0;
      case (state_q)
         ARB: begin
            if (xfer) begin
               if (hdr_len == '0) begin
                  pkt_done_d = 1'b1;
                  prio_d     = wrap_inc(arb_win);
               end else begin
                  grant_d      = arb_win;
                  flits_left_d = hdr_len;
                  state_d      = BODY;
               end
            end
         end
         BODY: begin
            if (xfer) begin
               flits_left_d = flits_left_q - MSG_LEN_W'(1);
               if (flits_left_q == MSG_LEN_W'(1)) begin
                  state_d    = ARB;
                  prio_d     = wrap_inc(grant_q);
                  pkt_done_d = 1'b1;
               end
            end
         end
         default: state_d = ARB;
      endcase
   end

   // State register; reset drops any open packet immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB;
         prio_q       <= '0;
         grant_q      <= '0;
         flits_left_q <= '0;
         arb_pkt_done <= 1'b0;
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         grant_q      <= grant_d;
         flits_left_q <= flits_left_d;
         arb_pkt_done <= pkt_done_d;
      end
   end

endmodule

// File: tb/tb_eth_rx_noc_out_arb.sv
// Bench for eth_rx_noc_out_arb: a directed cycle table followed by
// packet-stream sequences checked against a packet-level reference model.
module tb_eth_rx_noc_out_arb;
   localparam int N  = 2;
   localparam int DW = 64;
   localparam int LW = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [0:0] gidx;
   logic       done;

   eth_rx_noc_out_arb_if #(.NUM_SRCS(N), .DATA_W(DW)) bus ();

   eth_rx_noc_out_arb #(.NUM_SRCS(N), .DATA_W(DW), .MSG_LEN_LSB(0), .MSG_LEN_W(LW)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .arb_grant_idx (gidx),
      .arb_pkt_done  (done)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit       r;
      bit [1:0] v;
      bit [7:0] l0, l1;
      bit       nr;
      bit       ov;
      bit       os;
      bit [1:0] rd;
      bit       dn;
      bit       gi;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(bit r, bit [1:0] v, bit [7:0] l0, bit [7:0] l1, bit nr,
                               bit ov, bit os, bit [1:0] rd, bit dn, bit gi);
      vec_t x;
      x.r = r; x.v = v; x.l0 = l0; x.l1 = l1; x.nr = nr;
      x.ov = ov; x.os = os; x.rd = rd; x.dn = dn; x.gi = gi;
      return x;
   endfunction

   function automatic logic [63:0] tdata(int i, bit [7:0] len);
      return {8'(i + 1), 48'h0, len};
   endfunction

   // ---------------- reference model ----------------
   logic [63:0] srcq [N][$];
   bit [N-1:0]  force_off = '0;
   bit          tog = 1'b1;
   int          owner = -1, remaining = 0, prio = 0;
   bit          exp_done = 1'b0;
   int          pid = 0;
   int          dut_hs = 0, dut_done_cnt = 0;

   task automatic push_pkt(input int s, input int len);
      srcq[s].push_back({8'(s), 16'(pid), 16'(0), 16'h0, 8'(len)});
      for (int j = 1; j <= len; j++)
         srcq[s].push_back({8'(s), 16'(pid), 16'(j), 16'hB0D7, 8'($urandom)});
      pid++;
   endtask

   task automatic cycle(input int rdy_mode, input int bubble_pct, input bit r);
      bit [N-1:0]  v;
      bit [N-1:0]  er;
      bit          nr, ev;
      int          sel, exp_g, idx;
      logic [63:0] flit;
      @(negedge clk);
      rst = r;
      for (int i = 0; i < N; i++) begin
         v[i] = (srcq[i].size() > 0) && !force_off[i] && ($urandom_range(99) >= bubble_pct);
         bus.src_noc0_vrtoc_data[i*DW +: DW] = (srcq[i].size() > 0) ? srcq[i][0] : 64'h0;
      end
      case (rdy_mode)
         0:       nr = 1'($urandom_range(1));
         1:       begin nr = tog; tog = ~tog; end
         default: nr = 1'b1;
      endcase
      bus.src_noc0_vrtoc_val        = v;
      bus.noc0_vrtoc_eth_rx_out_rdy = nr;
      #1;
      sel = 0; ev = 1'b0; er = '0; exp_g = 0;
      if (owner >= 0) begin
         sel = owner; ev = v[owner]; er[owner] = nr; exp_g = owner;
      end else begin
         for (int k = 0; k < N; k++) begin
            idx = (prio + k) % N;
            if (!ev && v[idx]) begin
               sel = idx; ev = 1'b1; er[idx] = nr; exp_g = idx;
            end
         end
      end
      if (r) begin ev = 1'b0; er = '0; end
      chk("out_val", bus.eth_rx_out_noc0_vrtoc_val, ev);
      chk("src_rdy", bus.noc0_vrtoc_src_rdy, er);
      chk("pkt_done", done, exp_done);
      if (!r) chk("grant_idx", gidx, exp_g);
      if (ev) chk("out_data", bus.eth_rx_out_noc0_vrtoc_data, srcq[sel][0]);
      if (bus.eth_rx_out_noc0_vrtoc_val && nr) dut_hs++;
      if (done) dut_done_cnt++;
      if (r) begin
         owner = -1; remaining = 0; prio = 0; exp_done = 1'b0;
      end else begin
         exp_done = 1'b0;
         if (ev && nr) begin
            flit = srcq[sel].pop_front();
            if (owner < 0) begin
               if (flit[7:0] == 8'd0) begin
                  exp_done = 1'b1; prio = (sel + 1) % N;
               end else begin
                  owner = sel; remaining = int'(flit[7:0]);
               end
            end else begin
               remaining--;
               if (remaining == 0) begin
                  owner = -1; prio = (sel + 1) % N; exp_done = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic drain(input int mode, input int bubble, input int budget, input string name,
                        output int n);
      n = 0;
      while ((srcq[0].size() > 0 || srcq[1].size() > 0) && n < budget) begin
         cycle(mode, bubble, 1'b0);
         n++;
      end
      if (n >= budget) chk({name, "_timeout"}, n, 64'(budget - 1));
   endtask

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      vec_t t;
      tbl[0]  = mk(1, 2'b01, 3, 0, 1, 0, 0, 2'b00, 0, 0);
      tbl[1]  = mk(0, 2'b01, 3, 0, 1, 1, 0, 2'b01, 0, 0);
      tbl[2]  = mk(0, 2'b01, 7, 0, 1, 1, 0, 2'b01, 0, 0);
      tbl[3]  = mk(0, 2'b01, 7, 0, 1, 1, 0, 2'b01, 0, 0);
      tbl[4]  = mk(0, 2'b01, 7, 0, 1, 1, 0, 2'b01, 0, 0);
      tbl[5]  = mk(0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 1, 0);
      tbl[6]  = mk(0, 2'b11, 0, 0, 1, 1, 1, 2'b10, 0, 1);
      tbl[7]  = mk(0, 2'b11, 0, 0, 1, 1, 0, 2'b01, 1, 0);
      tbl[8]  = mk(0, 2'b11, 0, 0, 1, 1, 1, 2'b10, 1, 1);
      tbl[9]  = mk(0, 2'b11, 0, 0, 0, 1, 0, 2'b00, 1, 0);
      tbl[10] = mk(0, 2'b10, 0, 0, 0, 1, 1, 2'b00, 0, 1);
      tbl[11] = mk(0, 2'b10, 0, 2, 1, 1, 1, 2'b10, 0, 1);
      tbl[12] = mk(0, 2'b01, 0, 2, 1, 0, 0, 2'b10, 0, 1);
      tbl[13] = mk(0, 2'b11, 0, 9, 1, 1, 1, 2'b10, 0, 1);
      tbl[14] = mk(0, 2'b11, 0, 9, 1, 1, 1, 2'b10, 0, 1);
      tbl[15] = mk(0, 2'b01, 0, 0, 1, 1, 0, 2'b01, 1, 0);
      tbl[16] = mk(0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 1, 0);
      tbl[17] = mk(0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0);

      rst = 1'b1;
      bus.src_noc0_vrtoc_val        = '0;
      bus.src_noc0_vrtoc_data       = '0;
      bus.noc0_vrtoc_eth_rx_out_rdy = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 18; i++) begin
         t = tbl[i];
         @(negedge clk);
         rst = t.r;
         bus.src_noc0_vrtoc_val              = t.v;
         bus.src_noc0_vrtoc_data[0*DW +: DW] = tdata(0, t.l0);
         bus.src_noc0_vrtoc_data[1*DW +: DW] = tdata(1, t.l1);
         bus.noc0_vrtoc_eth_rx_out_rdy       = t.nr;
         #1;
         chk($sformatf("tbl%0d_val", i), bus.eth_rx_out_noc0_vrtoc_val, t.ov);
         chk($sformatf("tbl%0d_rdy", i), bus.noc0_vrtoc_src_rdy, t.rd);
         chk($sformatf("tbl%0d_done", i), done, t.dn);
         chk($sformatf("tbl%0d_gidx", i), gidx, t.gi);
         if (t.ov)
            chk($sformatf("tbl%0d_data", i), bus.eth_rx_out_noc0_vrtoc_data,
                tdata(int'(t.os), t.os ? t.l1 : t.l0));
      end

      // reset model and DUT together
      cycle(2, 0, 1'b1);
      cycle(2, 0, 1'b1);

      // back-to-back contention: src0, src1, src0 with no idle cycle
      push_pkt(0, 2); push_pkt(0, 2); push_pkt(1, 2);
      drain(2, 0, 40, "t2", n);
      chk("t2_cycles", n, 9);

      // src1 bubbles mid-body while src0 waits
      push_pkt(1, 4); push_pkt(0, 1);
      cycle(2, 0, 1'b0);
      cycle(2, 0, 1'b0);
      force_off[1] = 1'b1;
      cycle(2, 0, 1'b0);
      cycle(2, 0, 1'b0);
      force_off[1] = 1'b0;
      drain(2, 0, 40, "t3", n);

      // NoC ready toggling across a msg_len=5 packet, src1 contending
      push_pkt(0, 5);
      tog = 1'b1;
      dut_hs = 0;
      cycle(1, 0, 1'b0);
      push_pkt(1, 1);
      n = 0;
      while (srcq[0].size() > 0 && n < 30) begin
         cycle(1, 0, 1'b0);
         n++;
      end
      chk("t4_handshakes", dut_hs, 6);
      drain(2, 0, 20, "t4b", n);

      // header-only packets alternating one per cycle
      for (int i = 0; i < 6; i++) begin push_pkt(0, 0); push_pkt(1, 0); end
      cycle(2, 0, 1'b0);
      dut_done_cnt = 0;
      drain(2, 0, 40, "t5", n);
      chk("t5_cycles", n, 11);
      cycle(2, 0, 1'b0);
      chk("t5_done_pulses", dut_done_cnt, 12);

      // maximum msg_len under random ready and bubbles
      push_pkt(1, 255); push_pkt(0, 3);
      drain(0, 20, 3000, "max_len", n);

      // randomized packet mix
      for (int i = 0; i < 60; i++) push_pkt(int'($urandom_range(N - 1)), int'($urandom_range(9)));
      drain(0, 25, 6000, "rand", n);

      // reset asserted in cycle 2 of a msg_len=3 packet
      push_pkt(0, 3);
      cycle(2, 0, 1'b0);
      cycle(2, 0, 1'b0);
      push_pkt(1, 0);
      cycle(2, 0, 1'b1);
      cycle(2, 0, 1'b1);
      for (int i = 0; i < N; i++) srcq[i].delete();
      push_pkt(1, 0); push_pkt(0, 0);
      cycle(2, 0, 1'b0);
      chk("t6_src0_wins", bus.noc0_vrtoc_src_rdy, 2'b01);
      drain(2, 0, 10, "t6", n);
      cycle(2, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
